// File: rtl/spi_follower.sv
`default_nettype none
// ============================================================================
// Module   : spi_follower
// Purpose  : SPI follower (slave) clocked entirely by the system clock.
//            sclk/cs_n/mosi are resynchronised into clk and edges are detected
//            on the synchronised sclk. Supports all four cpol/cpha modes and
//            8- or 16-bit words, MSB first. A one-entry tx buffer feeds each
//            frame; an empty buffer at frame start sends all ones and pulses
//            underrun.
// Ports    : clk, rst (async, active-high)
//            sclk, cs_n, mosi       - SPI pins from the leader (asynchronous)
//            miso                   - SPI data to the leader
//            cpol, cpha, len        - mode/word length, captured at frame start
//            tx_data/tx_valid/tx_ready - tx word handshake
//            rx_data/rx_valid       - received word and one-clk update pulse
//            underrun               - one-clk pulse, frame began with no tx word
//            busy                   - FSM not idle
// Config   : define SPI_FOLLOWER_MISO_TRISTATE_EN to float miso (high-Z) while
//            idle or deselected; otherwise miso drives 1 in those conditions.
// Revision : 1.0 - initial release
// ============================================================================
module spi_follower #(
  parameter int SYNC_STAGES = 2  // legal 2..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        len,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        underrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // The synchroniser chain needs SYNC_STAGES clocks after reset to reflect the
  // real pins, plus one more for the delayed cs_n copy; until then a cs_n that
  // is already low would look like a fresh falling edge.
  localparam logic [2:0] SETTLE_CNT = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic        sclk_dly_q, sclk_dly_d;
  logic        cs_dly_q,   cs_dly_d;
  logic [2:0]  settle_q,   settle_d;
  state_t      state_q,    state_d;
  logic        cpol_q,     cpol_d;
  logic        cpha_q,     cpha_d;
  logic        len_q,      len_d;
  logic        tx_full_q,  tx_full_d;
  logic [15:0] tx_buf_q,   tx_buf_d;
  logic [15:0] tx_sr_q,    tx_sr_d;
  logic [15:0] rx_sr_q,    rx_sr_d;
  logic [4:0]  cnt_q,      cnt_d;
  logic        miso_q,     miso_d;
  logic [15:0] rx_data_q,  rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        underrun_q, underrun_d;
  logic        busy_q,     busy_d;

  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall;
  logic        lead_edge, trail_edge;
  logic        sample_edge, shift_edge;
  logic        armed;
  logic [15:0] load_word;
  logic [4:0]  bit_limit;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  // Leading edge leaves the cpol idle level, trailing edge returns to it.
  assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

  assign armed     = (settle_q == SETTLE_CNT);
  assign bit_limit = len_q ? 5'd16 : 5'd8;
  // The transmit word is always left-justified so bit 15 is the next bit out.
  assign load_word = !tx_full_q ? 16'hFFFF :
                     (len_q ? tx_buf_q : {tx_buf_q[7:0], 8'h00});

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    settle_d    = armed ? settle_q : settle_q + 3'd1;
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    len_d       = len_q;
    tx_full_d   = tx_full_q;
    tx_buf_d    = tx_buf_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b1;
        if (armed && cs_dly_q && !cs_s) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          len_d   = len;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // The buffer is consumed even if the frame is aborted this cycle.
        tx_full_d  = 1'b0;
        underrun_d = !tx_full_q;
        cnt_d      = 5'd0;
        rx_sr_d    = 16'h0000;
        if (!cpha_q) begin
          miso_d  = load_word[15];
          tx_sr_d = {load_word[14:0], 1'b0};
        end else begin
          tx_sr_d = load_word;
        end
        state_d = cs_s ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        // A deselect beats any sclk edge seen in the same cycle.
        if (cs_s) begin
          state_d = S_IDLE;
        end else begin
          if (shift_edge) begin
            miso_d  = tx_sr_q[15];
            tx_sr_d = {tx_sr_q[14:0], 1'b0};
          end
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[14:0], mosi_s};
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q + 5'd1 == bit_limit) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        rx_data_d  = len_q ? rx_sr_q : {8'h00, rx_sr_q[7:0]};
        rx_valid_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Extra sclk edges are ignored and miso holds until deselect.
        if (cs_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accepting after the LOAD update lets a word arriving during LOAD be
    // kept for the following frame.
    if (tx_valid && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_buf_d  = tx_data;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      settle_q    <= 3'd0;
      state_q     <= S_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      len_q       <= 1'b0;
      tx_full_q   <= 1'b0;
      tx_buf_q    <= 16'h0000;
      tx_sr_q     <= 16'h0000;
      rx_sr_q     <= 16'h0000;
      cnt_q       <= 5'd0;
      miso_q      <= 1'b1;
      rx_data_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      settle_q    <= settle_d;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      len_q       <= len_d;
      tx_full_q   <= tx_full_d;
      tx_buf_q    <= tx_buf_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign busy     = busy_q;

`ifdef SPI_FOLLOWER_MISO_TRISTATE_EN
  assign miso = ((state_q == S_IDLE) || cs_s) ? 1'bz : miso_q;
`else
  assign miso = ((state_q == S_IDLE) || cs_s) ? 1'b1 : miso_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_follower.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_follower
// Purpose  : Directed bench for spi_follower. A leader model drives frames in
//            all four modes; expected rx words are queued when each frame is
//            issued and a monitor pops and compares on every rx_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_follower;

  localparam int SYNC = 2;
  localparam int HALF = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, cs_n, mosi;
  wire         miso;
  logic        cpol, cpha, len;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, underrun, busy;

  spi_follower #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .cpol(cpol), .cpha(cpha), .len(len), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int last_rx_cyc = 0;
  int last_samp_cyc = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt = rx_cnt + 1;
      last_rx_cyc = cyc;
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL rx_unexpected: got rx_data %h with no word expected", rx_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          n_err = n_err + 1;
          $display("FAIL rx_data: got %h expected %h", rx_data, e);
        end
      end
    end
    if (underrun) ur_cnt = ur_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_tx(input logic [15:0] w);
    int k = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && k < 20) begin
      wait_clk(1);
      k++;
    end
    if (k == 20) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL tx_handshake: got tx_ready 0 expected 1 within 20 clk");
    end
    wait_clk(1);
    tx_valid = 1'b0;
    check("tx_ready_after_accept", {15'b0, tx_ready}, 16'h0000);
  endtask

  task automatic frame_start(input logic pol, input logic pha, input logic ln);
    cpol = pol; cpha = pha; len = ln;
    sclk = pol;
    wait_clk(4);
    cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  // Sends nsend bits of word (nbits long, MSB first); returns miso bits seen.
  task automatic frame_bits(input logic [15:0] word, input int nbits, input int nsend,
                            output logic [15:0] got);
    got = 16'h0000;
    for (int i = 0; i < nsend; i++) begin
      if (!cpha) begin
        mosi = word[nbits-1-i];
        wait_clk(HALF);
        sclk = ~sclk;
        last_samp_cyc = cyc;
        got = {got[14:0], miso};
        wait_clk(HALF);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = word[nbits-1-i];
        wait_clk(HALF);
        sclk = ~sclk;
        last_samp_cyc = cyc;
        got = {got[14:0], miso};
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  logic [15:0] got;
  int rx0, ur0;

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; len = 1'b0; tx_data = 16'h0000; tx_valid = 1'b0;
    wait_clk(3);
    // Reset state
    check("reset_tx_ready", {15'b0, tx_ready}, 16'h0001);
    check("reset_rx_valid", {15'b0, rx_valid}, 16'h0000);
    check("reset_underrun", {15'b0, underrun}, 16'h0000);
    check("reset_busy",     {15'b0, busy},     16'h0000);
    check("reset_rx_data",  rx_data,           16'h0000);
`ifndef SPI_FOLLOWER_MISO_TRISTATE_EN
    check("reset_miso",     {15'b0, miso},     16'h0001);
`endif
    rst = 1'b0;
    wait_clk(SYNC + 4);

    // Mode 0, 8-bit: tx 0xA5, leader sends 0x3C
    send_tx(16'h00A5);
    exp_q.push_back(16'h003C);
    rx0 = rx_cnt;
    frame_start(1'b0, 1'b0, 1'b0);
    check("m0_busy", {15'b0, busy}, 16'h0001);
    frame_bits(16'h003C, 8, 8, got);
    frame_end();
    check("m0_miso", got, 16'h00A5);
    check("m0_rx_count", 16'(rx_cnt - rx0), 16'h0001);
    check("m0_rx_latency", 16'(last_rx_cyc - last_samp_cyc), 16'(SYNC + 2));
    check("m0_rx_data", rx_data, 16'h003C);

    // Mode 3, 16-bit: tx 0x1234, leader sends 0xBEEF
    send_tx(16'h1234);
    exp_q.push_back(16'hBEEF);
    frame_start(1'b1, 1'b1, 1'b1);
    check("m3_tx_ready_after_load", {15'b0, tx_ready}, 16'h0001);
    frame_bits(16'hBEEF, 16, 16, got);
    frame_end();
    check("m3_miso", got, 16'h1234);

    // Mode 1, empty buffer: underrun, all ones, rx still delivered
    ur0 = ur_cnt;
    exp_q.push_back(16'h005A);
    frame_start(1'b0, 1'b1, 1'b0);
    frame_bits(16'h005A, 8, 8, got);
    frame_end();
    check("m1_underrun_count", 16'(ur_cnt - ur0), 16'h0001);
    check("m1_miso_ones", got, 16'h00FF);
    check("m1_rx_data", rx_data, 16'h005A);

    // Mode 2 abort after 5 of 8 bits
    rx0 = rx_cnt;
    frame_start(1'b1, 1'b0, 1'b0);
    frame_bits(16'h00C3, 8, 5, got);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(SYNC + 1);
    check("abort_busy_low", {15'b0, busy}, 16'h0000);
    wait_clk(20);
    check("abort_no_rx", 16'(rx_cnt - rx0), 16'h0000);
    check("abort_rx_data_kept", rx_data, 16'h005A);
    check("abort_miso_ones", got, 16'h001F);

    // Reset mid-frame, then a clean 16-bit 0x00FF frame
    rx0 = rx_cnt;
    frame_start(1'b0, 1'b0, 1'b1);
    frame_bits(16'hA5A5, 16, 3, got);
    rst = 1'b1;
    wait_clk(3);
    check("midrst_rx_data", rx_data, 16'h0000);
    rst = 1'b0;
    wait_clk(20);
    check("midrst_no_restart", {15'b0, busy}, 16'h0000);
    cs_n = 1'b1;
    wait_clk(HALF);
    exp_q.push_back(16'h00FF);
    frame_start(1'b0, 1'b0, 1'b1);
    frame_bits(16'h00FF, 16, 16, got);
    frame_end();
    check("midrst_rx_count", 16'(rx_cnt - rx0), 16'h0001);
    check("midrst_miso_ones", got, 16'hFFFF);

    // Extra sclk cycles after an 8-bit frame are ignored
    send_tx(16'h00C2);
    exp_q.push_back(16'h0081);
    rx0 = rx_cnt;
    frame_start(1'b0, 1'b0, 1'b0);
    frame_bits(16'h0081, 8, 8, got);
    check("extra_miso", got, 16'h00C2);
    for (int i = 0; i < 4; i++) begin
      wait_clk(HALF);
      sclk = ~sclk;
      wait_clk(HALF);
      check("extra_miso_hold", {15'b0, miso}, 16'h0000);
      sclk = ~sclk;
    end
    wait_clk(HALF);
    check("extra_busy_wait", {15'b0, busy}, 16'h0001);
    frame_end();
    check("extra_rx_count", 16'(rx_cnt - rx0), 16'h0001);
    check("extra_busy_idle", {15'b0, busy}, 16'h0000);
`ifndef SPI_FOLLOWER_MISO_TRISTATE_EN
    check("extra_miso_idle", {15'b0, miso}, 16'h0001);
`endif

    wait_clk(10);
    check("total_rx_count", 16'(rx_cnt), 16'd5);
    check("total_underruns", 16'(ur_cnt), 16'd4);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
